pim_indirect_seq: RTL and testbench

Sequencer that turns the indirect-argument registers (A = index-table base, B = target base, C = count/scale) into a stream of PIM command addresses. It fetches 256-bit index beats (8 × 32-bit indices) through a read port, computes target = B + (idx << shift) per lane, and issues each address on a valid/ready command port. It sits between the indirect-argument register block and the PIM request path.

---
 rtl/pim_indirect_pkg.sv | 36 +++
 rtl/pim_indirect_seq_if.sv | 25 ++
 rtl/pim_indirect_addr_calc.sv | 46 ++++
 rtl/pim_indirect_seq.sv | 216 +++++++++++++++++++++
 tb/tb_pim_indirect_seq.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pim_indirect_pkg.sv
// Shared constants, FSM state type and lane helper for the indirect-argument
// PIM command sequencer.
package pim_indirect_pkg;

  localparam int IDX_W  = 32;
  localparam int BEAT_W = 256;
  localparam int CNT_W  = 16;
  localparam int LANES  = BEAT_W / IDX_W;
  localparam int LANE_W = $clog2(LANES);
  localparam int SHF_W  = 5;

  // Field positions inside argument register C.
  localparam int C_CNT_LSB = 0;
  localparam int C_CNT_MSB = 15;
  localparam int C_SHF_LSB = 16;
  localparam int C_SHF_MSB = 20;

  // Byte size of one index beat; consecutive beats are this far apart.
  localparam logic [IDX_W-1:0]  BEAT_BYTES = 32'd32;
  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(LANES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Select one 32-bit index out of a beat; lane k sits at bits [32k+31:32k].
  function automatic logic [IDX_W-1:0] lane_word(input logic [BEAT_W-1:0] beat,
                                                 input logic [LANE_W-1:0] lane);
    lane_word = beat[int'(lane)*IDX_W +: IDX_W];
  endfunction

endpackage

// File: rtl/pim_indirect_seq_if.sv
// Index-read port and command port of the sequencer, bundled as one interface.
// The master side is the sequencer; the slave side is memory / PIM request path.
interface pim_indirect_seq_if;
  import pim_indirect_pkg::*;

  logic              o_idx_rd_req;
  logic [IDX_W-1:0]  o_idx_rd_addr;
  logic              i_idx_rd_ack;
  logic              i_idx_rd_valid;
  logic [BEAT_W-1:0] i_idx_rd_data;
  logic              o_cmd_valid;
  logic [IDX_W-1:0]  o_cmd_addr;
  logic              i_cmd_ready;

  modport master (
    output o_idx_rd_req, o_idx_rd_addr, o_cmd_valid, o_cmd_addr,
    input  i_idx_rd_ack, i_idx_rd_valid, i_idx_rd_data, i_cmd_ready
  );

  modport slave (
    input  o_idx_rd_req, o_idx_rd_addr, o_cmd_valid, o_cmd_addr,
    output i_idx_rd_ack, i_idx_rd_valid, i_idx_rd_data, i_cmd_ready
  );

endinterface

// File: rtl/pim_indirect_addr_calc.sv
// Registered target-address generator: addr = base + (beat[lane] << shift),
// wrapping mod 2^32. The register only changes on load or clear so the
// command address stays stable while a command waits for ready.
module pim_indirect_addr_calc
  import pim_indirect_pkg::*;
(
  input  logic              clk,
  input  logic              rst_x,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [BEAT_W-1:0] beat_i,
  input  logic [LANE_W-1:0] lane_i,
  input  logic [IDX_W-1:0]  base_i,
  input  logic [SHF_W-1:0]  shift_i,
  output logic [IDX_W-1:0]  addr_o
);

  logic [IDX_W-1:0] idx_s;
  logic [IDX_W-1:0] addr_d;
  logic [IDX_W-1:0] addr_q;

  // Next address: clear wins, then load a freshly computed lane address, else hold.
  always_comb begin
    idx_s  = lane_word(beat_i, lane_i);
    addr_d = addr_q;
    if (clr_i) begin
      addr_d = 32'h0000_0000;
    end else if (load_i) begin
      addr_d = base_i + (idx_s << shift_i);
    end else begin
      addr_d = addr_q;
    end
  end

  // Address register.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      addr_q <= 32'h0000_0000;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/pim_indirect_seq.sv
// Indirect-argument sequencer: walks an index table N entries long, one
// 8-index beat at a time, and issues B + (idx << S) for each element on the
// command port.
module pim_indirect_seq
  import pim_indirect_pkg::*;
(
  input  logic               clk,
  input  logic               rst_x,
  input  logic               i_start,
  input  logic [IDX_W-1:0]   i_args_reg_A,
  input  logic [IDX_W-1:0]   i_args_reg_B,
  input  logic [IDX_W-1:0]   i_args_reg_C,
  input  logic               i_HPC_clear,
  input  logic               i_PIM_dev_working,
  pim_indirect_seq_if.master bus,
  output logic               o_busy,
  output logic               o_done,
  output logic [CNT_W-1:0]   o_issued_cnt
);

  state_e            state_q,     state_d;
  logic              req_q,       req_d;
  logic [IDX_W-1:0]  rd_addr_q,   rd_addr_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              done_q,      done_d;
  logic              busy_q,      busy_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [LANE_W-1:0] lane_q,      lane_d;
  logic [BEAT_W-1:0] beat_q,      beat_d;
  logic [IDX_W-1:0]  b_q,         b_d;
  logic [CNT_W-1:0]  n_q,         n_d;
  logic [SHF_W-1:0]  s_q,         s_d;

  logic              load_s;
  logic [LANE_W-1:0] lane_sel_s;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic              accept_s;
  logic [IDX_W-1:0]  cmd_addr_s;
  logic              unused_c_s;

  // Upper bits of C carry no meaning for this block.
  assign unused_c_s = ^i_args_reg_C[IDX_W-1:C_SHF_MSB+1];

  assign cnt_inc_s = cnt_q + 16'd1;
  assign accept_s  = cmd_valid_q & bus.i_cmd_ready;

  // Next-state and output decode; the abort input overrides every state.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rd_addr_d   = rd_addr_q;
    cmd_valid_d = cmd_valid_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    beat_d      = beat_q;
    b_d         = b_q;
    n_d         = n_q;
    s_d         = s_q;
    load_s      = 1'b0;
    lane_sel_s  = lane_q;

    if (i_HPC_clear) begin
      state_d     = ST_IDLE;
      req_d       = 1'b0;
      cmd_valid_d = 1'b0;
      cnt_d       = 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            b_d    = i_args_reg_B;
            n_d    = i_args_reg_C[C_CNT_MSB:C_CNT_LSB];
            s_d    = i_args_reg_C[C_SHF_MSB:C_SHF_LSB];
            cnt_d  = 16'd0;
            lane_d = {LANE_W{1'b0}};
            if (i_args_reg_C[C_CNT_MSB:C_CNT_LSB] != 16'd0) begin
              state_d   = ST_FETCH;
              req_d     = 1'b1;
              rd_addr_d = i_args_reg_A;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_FETCH: begin
          if (bus.i_idx_rd_ack) begin
            req_d = 1'b0;
            if (bus.i_idx_rd_valid) begin
              beat_d  = bus.i_idx_rd_data;
              lane_d  = {LANE_W{1'b0}};
              state_d = ST_ISSUE;
            end else begin
              state_d = ST_WAIT;
            end
          end else begin
            state_d = ST_FETCH;
          end
        end

        ST_WAIT: begin
          if (bus.i_idx_rd_valid) begin
            beat_d  = bus.i_idx_rd_data;
            lane_d  = {LANE_W{1'b0}};
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_WAIT;
          end
        end

        ST_ISSUE: begin
          if (cmd_valid_q) begin
            // Once presented, a command holds until accepted.
            if (accept_s) begin
              cnt_d       = cnt_inc_s;
              cmd_valid_d = 1'b0;
              if (cnt_inc_s == n_q) begin
                state_d = ST_DONE;
              end else if (lane_q == LAST_LANE) begin
                state_d   = ST_FETCH;
                req_d     = 1'b1;
                rd_addr_d = rd_addr_q + BEAT_BYTES;
              end else begin
                lane_d     = lane_q + 3'd1;
                lane_sel_s = lane_q + 3'd1;
                // Chain the next lane straight away to sustain one per cycle.
                if (!i_PIM_dev_working) begin
                  load_s      = 1'b1;
                  cmd_valid_d = 1'b1;
                end else begin
                  cmd_valid_d = 1'b0;
                end
              end
            end else begin
              cmd_valid_d = 1'b1;
            end
          end else if (!i_PIM_dev_working) begin
            load_s      = 1'b1;
            cmd_valid_d = 1'b1;
          end else begin
            cmd_valid_d = 1'b0;
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end

        default: begin
          state_d     = ST_IDLE;
          req_d       = 1'b0;
          cmd_valid_d = 1'b0;
        end
      endcase
    end

    // Busy also covers the done-pulse cycle so a run reads as one busy window.
    busy_d = (state_d != ST_IDLE) || done_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      rd_addr_q   <= 32'h0000_0000;
      cmd_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= 16'd0;
      lane_q      <= 3'd0;
      beat_q      <= 256'd0;
      b_q         <= 32'h0000_0000;
      n_q         <= 16'd0;
      s_q         <= 5'd0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rd_addr_q   <= rd_addr_d;
      cmd_valid_q <= cmd_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      beat_q      <= beat_d;
      b_q         <= b_d;
      n_q         <= n_d;
      s_q         <= s_d;
    end
  end

  pim_indirect_addr_calc u_addr_calc (
    .clk     (clk),
    .rst_x   (rst_x),
    .clr_i   (i_HPC_clear),
    .load_i  (load_s),
    .beat_i  (beat_q),
    .lane_i  (lane_sel_s),
    .base_i  (b_q),
    .shift_i (s_q),
    .addr_o  (cmd_addr_s)
  );

  assign bus.o_idx_rd_req  = req_q;
  assign bus.o_idx_rd_addr = rd_addr_q;
  assign bus.o_cmd_valid   = cmd_valid_q;
  assign bus.o_cmd_addr    = cmd_addr_s;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_issued_cnt      = cnt_q;

endmodule

// File: tb/tb_pim_indirect_seq.sv
// Directed bench for pim_indirect_seq: table of full runs plus hand-written
// sequences for stalls, abort, ignored start and async reset.
module tb_pim_indirect_seq;
  import pim_indirect_pkg::*;

  logic        clk = 1'b0;
  logic        rst_x;
  logic        start;
  logic [31:0] arg_a, arg_b, arg_c;
  logic        clear;
  logic        working;
  logic        busy, done;
  logic [15:0] cnt;

  pim_indirect_seq_if bus();

  pim_indirect_seq dut (
    .clk               (clk),
    .rst_x             (rst_x),
    .i_start           (start),
    .i_args_reg_A      (arg_a),
    .i_args_reg_B      (arg_b),
    .i_args_reg_C      (arg_c),
    .i_HPC_clear       (clear),
    .i_PIM_dev_working (working),
    .bus               (bus),
    .o_busy            (busy),
    .o_done            (done),
    .o_issued_cnt      (cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0]  a, b, c;
    logic         same_cycle;
    logic [255:0] beat0, beat1;
    int           nexp;
    int           nreads;
    logic [31:0]  exp [10];
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
  endtask

  function automatic logic [255:0] beat8(input logic [31:0] l0, l1, l2, l3, l4, l5, l6, l7);
    beat8 = {l7, l6, l5, l4, l3, l2, l1, l0};
  endfunction

  task automatic idle_inputs();
    start = 1'b0; clear = 1'b0; working = 1'b0;
    arg_a = 32'h0; arg_b = 32'h0; arg_c = 32'h0;
    bus.i_idx_rd_ack = 1'b0; bus.i_idx_rd_valid = 1'b0;
    bus.i_idx_rd_data = 256'h0; bus.i_cmd_ready = 1'b0;
  endtask

  // Waits (bounded) for a read request at a negedge, checks its address, and
  // returns the beat either in the ack cycle or one cycle later.
  task automatic serve_read(input string tag, input logic [31:0] exp_addr,
                            input logic [255:0] data, input bit delayed);
    int w = 0;
    while (bus.o_idx_rd_req !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_req_seen"}, 32'(bus.o_idx_rd_req), 32'd1);
    check({tag, "_rd_addr"}, bus.o_idx_rd_addr, exp_addr);
    bus.i_idx_rd_ack   = 1'b1;
    bus.i_idx_rd_valid = !delayed;
    bus.i_idx_rd_data  = data;
    @(negedge clk);
    bus.i_idx_rd_ack   = 1'b0;
    bus.i_idx_rd_valid = delayed;
    if (delayed) begin
      @(negedge clk);
      bus.i_idx_rd_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    int w = 0;
    while (done !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  initial begin
    idle_inputs();
    rst_x = 1'b0;

    // ---------------- vector table ----------------
    vecs[0].a = 32'h0000_1000; vecs[0].b = 32'h8000_0000; vecs[0].c = 32'h0002_0003;
    vecs[0].same_cycle = 1'b1; vecs[0].nexp = 3; vecs[0].nreads = 1;
    vecs[0].beat0 = beat8(32'd5, 32'd0, 32'd7, 32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD);
    vecs[0].beat1 = 256'h0;
    vecs[0].exp = '{32'h8000_0014, 32'h8000_0000, 32'h8000_001C, 32'h0, 32'h0,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    vecs[1].a = 32'h0000_2000; vecs[1].b = 32'h0000_0100; vecs[1].c = 32'h0000_000A;
    vecs[1].same_cycle = 1'b0; vecs[1].nexp = 10; vecs[1].nreads = 2;
    vecs[1].beat0 = beat8(32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C);
    vecs[1].beat1 = beat8(32'h40, 32'h44, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF);
    vecs[1].exp = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110,
                    32'h114, 32'h118, 32'h11C, 32'h140, 32'h144};

    vecs[2].a = 32'hFFFF_FFE0; vecs[2].b = 32'hFFFF_FFF0; vecs[2].c = 32'h0004_0009;
    vecs[2].same_cycle = 1'b1; vecs[2].nexp = 9; vecs[2].nreads = 2;
    vecs[2].beat0 = beat8(32'h10, 32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6);
    vecs[2].beat1 = beat8(32'hFF, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1);
    vecs[2].exp = '{32'h0000_00F0, 32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_0010, 32'h0000_0020,
                    32'h0000_0030, 32'h0000_0040, 32'h0000_0050, 32'h0000_0FE0, 32'h0};

    vecs[3].a = 32'h0000_0040; vecs[3].b = 32'h0000_0000; vecs[3].c = 32'hFFE8_0002;
    vecs[3].same_cycle = 1'b0; vecs[3].nexp = 2; vecs[3].nreads = 1;
    vecs[3].beat0 = beat8(32'h0001_2345, 32'h00FF_FFFF, 32'h9, 32'h9, 32'h9, 32'h9, 32'h9, 32'h9);
    vecs[3].beat1 = 256'h0;
    vecs[3].exp = '{32'h0123_4500, 32'hFFFF_FF00, 32'h0, 32'h0, 32'h0,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    // ---------------- reset state ----------------
    #12;
    check("rst_req",   32'(bus.o_idx_rd_req), 32'd0);
    check("rst_valid", 32'(bus.o_cmd_valid),  32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_cnt",   32'(cnt),  32'd0);
    check("rst_addr",  bus.o_cmd_addr, 32'd0);
    @(negedge clk);
    rst_x = 1'b1;
    @(negedge clk);

    // ---------------- table-driven full runs ----------------
    for (int v = 0; v < 4; v++) begin
      int  ncmd, nrd, ndone;
      bit  pend, fin;
      string t;
      t = $sformatf("v%0d", v);
      ncmd = 0; nrd = 0; ndone = 0; pend = 1'b0; fin = 1'b0;
      arg_a = vecs[v].a; arg_b = vecs[v].b; arg_c = vecs[v].c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      arg_a = 32'h0BAD_0000; arg_b = 32'h0BAD_0000; arg_c = 32'h0000_0001;
      check({t, "_req_latency"}, 32'(bus.o_idx_rd_req), 32'd1);
      check({t, "_busy"}, 32'(busy), 32'd1);
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
        if (cyc > 0) @(negedge clk);
        bus.i_idx_rd_ack = 1'b0; bus.i_idx_rd_valid = 1'b0;
        if (bus.o_idx_rd_req) begin
          check($sformatf("%s_rd%0d_addr", t, nrd), bus.o_idx_rd_addr, vecs[v].a + 32'(nrd) * 32'd32);
          bus.i_idx_rd_ack  = 1'b1;
          bus.i_idx_rd_data = (nrd == 0) ? vecs[v].beat0 : vecs[v].beat1;
          if (vecs[v].same_cycle) bus.i_idx_rd_valid = 1'b1;
          else pend = 1'b1;
          nrd++;
        end else if (pend) begin
          bus.i_idx_rd_valid = 1'b1;
          pend = 1'b0;
        end
        bus.i_cmd_ready = 1'b1;
        if (bus.o_cmd_valid) begin
          if (ncmd < vecs[v].nexp)
            check($sformatf("%s_cmd%0d", t, ncmd), bus.o_cmd_addr, vecs[v].exp[ncmd]);
          else
            check($sformatf("%s_extra_cmd", t), 32'd1, 32'd0);
          ncmd++;
        end
        if (done) begin
          ndone++;
          fin = 1'b1;
          check({t, "_issued_cnt"}, 32'(cnt), 32'(vecs[v].nexp));
        end
      end
      check({t, "_finished"}, 32'(fin), 32'd1);
      bus.i_cmd_ready = 1'b0; bus.i_idx_rd_ack = 1'b0; bus.i_idx_rd_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (done) ndone++;
      end
      check({t, "_ncmd"},   32'(ncmd),  32'(vecs[v].nexp));
      check({t, "_nreads"}, 32'(nrd),   32'(vecs[v].nreads));
      check({t, "_ndone"},  32'(ndone), 32'd1);
      check({t, "_idle"},   32'(busy),  32'd0);
    end

    // ---------------- N = 0 ----------------
    begin
      int nbusy = 0, ndn = 0, done_at = -1, sawreq = 0, sawval = 0;
      arg_c = 32'h0003_0000; arg_a = 32'h0000_9000; start = 1'b1;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        start = 1'b0;
        if (busy) nbusy++;
        if (done) begin ndn++; done_at = k; end
        if (bus.o_idx_rd_req) sawreq = 1;
        if (bus.o_cmd_valid) sawval = 1;
      end
      check("n0_busy_cycles", 32'(nbusy), 32'd2);
      check("n0_done_count",  32'(ndn),   32'd1);
      check("n0_done_cycle",  32'(done_at), 32'd2);
      check("n0_no_req",      32'(sawreq), 32'd0);
      check("n0_no_cmd",      32'(sawval), 32'd0);
      check("n0_cnt",         32'(cnt),    32'd0);
    end

    // ---------------- dev_working gating and ready stall ----------------
    begin
      int w = 0;
      working = 1'b1; bus.i_cmd_ready = 1'b0;
      arg_a = 32'h0000_3000; arg_b = 32'h0; arg_c = 32'h0000_0002; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      serve_read("st", 32'h0000_3000, beat8(32'h11, 32'h22, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0), 1'b0);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check($sformatf("st_blocked%0d", k), 32'(bus.o_cmd_valid), 32'd0);
      end
      working = 1'b0;
      @(negedge clk);
      while (bus.o_cmd_valid !== 1'b1 && w < 5) begin
        @(negedge clk);
        w++;
      end
      check("st_valid_rise", 32'(bus.o_cmd_valid), 32'd1);
      check("st_addr0", bus.o_cmd_addr, 32'h11);
      for (int k = 0; k < 5; k++) begin
        working = (k % 2 == 0);
        @(negedge clk);
        check($sformatf("st_hold_valid%0d", k), 32'(bus.o_cmd_valid), 32'd1);
        check($sformatf("st_hold_addr%0d", k), bus.o_cmd_addr, 32'h11);
      end
      working = 1'b0; bus.i_cmd_ready = 1'b1;
      @(negedge clk);
      check("st_b2b_valid", 32'(bus.o_cmd_valid), 32'd1);
      check("st_b2b_addr",  bus.o_cmd_addr, 32'h22);
      wait_done("st");
      check("st_cnt", 32'(cnt), 32'd2);
      bus.i_cmd_ready = 1'b0;
      @(negedge clk);
    end

    // ---------------- abort mid-run ----------------
    begin
      int acc = 0, w = 0;
      logic anyv;
      arg_a = 32'h0000_4000; arg_b = 32'h10; arg_c = 32'h0000_0008; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      serve_read("ab", 32'h0000_4000, beat8(32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7), 1'b1);
      bus.i_cmd_ready = 1'b1;
      while (acc < 4 && w < 30) begin
        @(negedge clk);
        w++;
        if (bus.o_cmd_valid) begin
          check($sformatf("ab_cmd%0d", acc), bus.o_cmd_addr, 32'h10 + 32'(acc));
          acc++;
        end
      end
      @(negedge clk);
      bus.i_cmd_ready = 1'b0; clear = 1'b1;
      check("ab_cnt_before", 32'(cnt), 32'd4);
      @(negedge clk);
      clear = 1'b0;
      check("ab_busy",  32'(busy), 32'd0);
      check("ab_valid", 32'(bus.o_cmd_valid), 32'd0);
      check("ab_req",   32'(bus.o_idx_rd_req), 32'd0);
      check("ab_cnt",   32'(cnt), 32'd0);
      bus.i_idx_rd_valid = 1'b1; bus.i_idx_rd_data = beat8(32'h7, 32'h7, 32'h7, 32'h7, 32'h7, 32'h7, 32'h7, 32'h7);
      anyv = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        bus.i_idx_rd_valid = 1'b0;
        anyv = anyv | done | busy | bus.o_cmd_valid | bus.o_idx_rd_req;
      end
      check("ab_quiet_after", 32'(anyv), 32'd0);
    end

    // ---------------- start while busy is ignored ----------------
    begin
      int w = 0;
      arg_a = 32'h0000_5000; arg_b = 32'h0; arg_c = 32'h0000_0001; start = 1'b1;
      @(negedge clk);
      arg_a = 32'h0000_6000; arg_b = 32'h0000_9000; arg_c = 32'h0000_0003;
      @(negedge clk);
      start = 1'b0;
      check("ign_req_held", 32'(bus.o_idx_rd_req), 32'd1);
      check("ign_rd_addr",  bus.o_idx_rd_addr, 32'h0000_5000);
      serve_read("ign", 32'h0000_5000, beat8(32'h7, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1), 1'b0);
      bus.i_cmd_ready = 1'b1;
      while (bus.o_cmd_valid !== 1'b1 && w < 10) begin
        @(negedge clk);
        w++;
      end
      check("ign_cmd", bus.o_cmd_addr, 32'h7);
      wait_done("ign");
      check("ign_cnt", 32'(cnt), 32'd1);
      bus.i_cmd_ready = 1'b0;
      @(negedge clk);
    end

    // ---------------- simultaneous start and clear ----------------
    arg_a = 32'h0000_7000; arg_c = 32'h0000_0005; start = 1'b1; clear = 1'b1;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    check("sc_busy", 32'(busy), 32'd0);
    check("sc_req",  32'(bus.o_idx_rd_req), 32'd0);
    @(negedge clk);
    check("sc_req_later", 32'(bus.o_idx_rd_req), 32'd0);

    // ---------------- async reset mid-run ----------------
    arg_a = 32'h0000_8000; arg_c = 32'h0000_0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ar_req_before", 32'(bus.o_idx_rd_req), 32'd1);
    #2 rst_x = 1'b0;
    #1;
    check("ar_req",  32'(bus.o_idx_rd_req), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_x = 1'b1;
    @(negedge clk);
    check("ar_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
